// File: rtl/block_serializer.sv
// block_serializer: FIFO of sorted blocks streamed out one element per cycle under backpressure
module block_serializer #(
  parameter int ELEM_W = 32,
  parameter int NELEM  = 16,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ELEM_W*NELEM-1:0] din,
  input  logic                    din_valid,
  input  logic                    din_last,
  input  logic                    rev_mode,
  input  logic                    full,
  output logic [ELEM_W-1:0]       dout,
  output logic                    dout_enq,
  output logic                    dout_last,
  output logic                    req,
  output logic [CNT_W-1:0]        fifo_cnt,
  output logic                    overflow
);
  localparam int IW = $clog2(NELEM);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = ELEM_W * NELEM;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  logic [BW:0] mem [DEPTH];
  logic [BW:0] head;
  logic [AW-1:0] wp, rp;
  logic [CNT_W-1:0] cnt;
  logic [IW-1:0] idx, sel;
  logic ord_q, ord, at_end, deq, wr;
  always_comb begin
    head = mem[rp];
    at_end = &idx;
    ord = (idx == '0) ? rev_mode : ord_q;
    sel = ord ? ~idx : idx;
    dout_enq = ~full & (cnt != '0);
    deq = dout_enq & at_end;
    wr = din_valid & ((cnt != CNT_FULL) | deq);
    dout = head[int'(sel)*ELEM_W +: ELEM_W];
    dout_last = deq & head[BW];
    req = (cnt < CNT_FULL) | deq;
  end
  assign fifo_cnt = cnt;
  always_ff @(posedge clk)
    if (wr) mem[wp] <= {din_last, din};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      idx <= '0;
      ord_q <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (deq) rp <= rp + 1'b1;
      if (wr != deq) cnt <= wr ? cnt + 1'b1 : cnt - 1'b1;
      if (dout_enq) idx <= idx + 1'b1;
      if (dout_enq && idx == '0) ord_q <= rev_mode;
      if (din_valid && !wr) overflow <= 1'b1;
    end
endmodule
